// File: rtl/joy_turbo_map.sv
// Joystick-to-PC-FX pad mapper with SOCD cleaning, shared turbo clock
// and per-port mode toggles, refreshed once per frame strobe.
module joy_turbo_map #(
  parameter int N_PORTS      = 2,
  parameter int TURBO_FRAMES = 4,
  parameter int SOCD_NEUTRAL = 1
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic [32*N_PORTS-1:0]  joy_in,
  input  logic [2*N_PORTS-1:0]   turbo_en,
  input  logic                   vsync_tick,
  output logic [16*N_PORTS-1:0]  pad_out,
  output logic                   pad_valid,
  output logic                   turbo_phase
);

  localparam logic [7:0] LAST = 8'(TURBO_FRAMES - 1);

  logic [7:0]           frame_cnt;
  logic [7:0]           cnt_nx;
  logic                 phase_nx;
  logic                 primed;
  logic [N_PORTS-1:0]   mode1, mode2;
  logic [N_PORTS-1:0]   hist1, hist2;
  logic [N_PORTS-1:0]   mode1_nx, mode2_nx;
  logic [N_PORTS-1:0]   cur1, cur2;
  logic [16*N_PORTS-1:0] pad_nx;
  logic                 unused_joy;

  assign unused_joy = ^joy_in;

  always_comb begin
    cnt_nx   = frame_cnt;
    phase_nx = turbo_phase;
    if (vsync_tick) begin
      if (frame_cnt == LAST) begin
        cnt_nx   = 8'd0;
        phase_nx = ~turbo_phase;
      end else begin
        cnt_nx = frame_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    logic [13:0] w;
    logic up, dn, lt, rt, b1, b2;
    pad_nx   = '0;
    mode1_nx = mode1;
    mode2_nx = mode2;
    cur1     = '0;
    cur2     = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      w = joy_in[32*p +: 14];
      cur1[p] = w[12];
      cur2[p] = w[13];
      // History is not trusted on the first cycle out of reset
      mode1_nx[p] = mode1[p] ^ (primed & w[12] & ~hist1[p]);
      mode2_nx[p] = mode2[p] ^ (primed & w[13] & ~hist2[p]);
      up = w[3];
      dn = w[2];
      lt = w[1];
      rt = w[0];
      if (SOCD_NEUTRAL != 0) begin
        if (up & dn) begin
          up = 1'b0;
          dn = 1'b0;
        end
        if (lt & rt) begin
          lt = 1'b0;
          rt = 1'b0;
        end
      end
      b1 = w[4] & (~turbo_en[2*p] | phase_nx);
      b2 = w[5] & (~turbo_en[2*p+1] | phase_nx);
      pad_nx[16*p +: 16] = {2'b00, mode2_nx[p], mode1_nx[p],
                            lt, dn, rt, up, w[7], w[6],
                            w[11:8], b2, b1};
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt   <= 8'd0;
      turbo_phase <= 1'b1;
      primed      <= 1'b0;
      mode1       <= '0;
      mode2       <= '0;
      hist1       <= '0;
      hist2       <= '0;
      pad_out     <= '0;
      pad_valid   <= 1'b0;
    end else begin
      frame_cnt   <= cnt_nx;
      turbo_phase <= phase_nx;
      primed      <= 1'b1;
      mode1       <= mode1_nx;
      mode2       <= mode2_nx;
      hist1       <= cur1;
      hist2       <= cur2;
      pad_valid   <= vsync_tick;
      if (vsync_tick) begin
        pad_out <= pad_nx;
      end
    end
  end

endmodule

// File: tb/tb_joy_turbo_map.sv
// Bench for joy_turbo_map: directed literal checks plus randomized
// traffic compared each cycle against a frame-level reference model.
module tb_joy_turbo_map;

  localparam int NP = 2;
  localparam int TF = 2;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic [63:0]   joy_in = '0;
  logic [3:0]    turbo_en = '0;
  logic          vsync_tick = 1'b0;
  logic [31:0]   pad_a, pad_b;
  logic          valid_a, valid_b;
  logic          phase_a, phase_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_sys = ~clk_sys;

  joy_turbo_map #(.N_PORTS(NP), .TURBO_FRAMES(TF), .SOCD_NEUTRAL(1)) dut_a (
    .clk_sys(clk_sys), .reset_n(reset_n), .joy_in(joy_in),
    .turbo_en(turbo_en), .vsync_tick(vsync_tick),
    .pad_out(pad_a), .pad_valid(valid_a), .turbo_phase(phase_a));

  joy_turbo_map #(.N_PORTS(NP), .TURBO_FRAMES(TF), .SOCD_NEUTRAL(0)) dut_b (
    .clk_sys(clk_sys), .reset_n(reset_n), .joy_in(joy_in),
    .turbo_en(turbo_en), .vsync_tick(vsync_tick),
    .pad_out(pad_b), .pad_valid(valid_b), .turbo_phase(phase_b));

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] fmt(input logic [31:0] w, input bit socd,
                                      input bit ph, input logic [1:0] en,
                                      input bit m1, input bit m2);
    logic [15:0] r;
    bit u, d, l, rt;
    u = w[3]; d = w[2]; l = w[1]; rt = w[0];
    if (socd && u && d) begin u = 0; d = 0; end
    if (socd && l && rt) begin l = 0; rt = 0; end
    r = '0;
    r[0] = w[4] && (!en[0] || ph);
    r[1] = w[5] && (!en[1] || ph);
    r[2] = w[8]; r[3] = w[9]; r[4] = w[10]; r[5] = w[11];
    r[6] = w[6]; r[7] = w[7];
    r[8] = u; r[9] = rt; r[10] = d; r[11] = l;
    r[12] = m1; r[13] = m2;
    return r;
  endfunction

  // Reference model: frame count as an integer, modes as toggle flags
  int          cnt;
  bit          ph, primed;
  bit          m1[NP], m2[NP], p1[NP], p2[NP];
  logic [31:0] ea, eb;
  bit          ev;

  initial begin
    logic [31:0] w;
    forever begin
      @(posedge clk_sys);
      if (!reset_n) begin
        cnt = 0; ph = 1; primed = 0; ea = '0; eb = '0; ev = 0;
        for (int p = 0; p < NP; p++) begin
          m1[p] = 0; m2[p] = 0; p1[p] = 0; p2[p] = 0;
        end
      end else begin
        for (int p = 0; p < NP; p++) begin
          w = joy_in[32*p +: 32];
          if (primed && w[12] && !p1[p]) m1[p] = !m1[p];
          if (primed && w[13] && !p2[p]) m2[p] = !m2[p];
          p1[p] = w[12]; p2[p] = w[13];
        end
        if (vsync_tick) begin
          cnt = cnt + 1;
          if (cnt == TF) begin cnt = 0; ph = !ph; end
          for (int p = 0; p < NP; p++) begin
            w = joy_in[32*p +: 32];
            ea[16*p +: 16] = fmt(w, 1, ph, turbo_en[2*p +: 2], m1[p], m2[p]);
            eb[16*p +: 16] = fmt(w, 0, ph, turbo_en[2*p +: 2], m1[p], m2[p]);
          end
        end
        ev = vsync_tick;
        primed = 1;
      end
      #1;
      chk("model pad_a", 64'(pad_a), 64'(ea));
      chk("model pad_b", 64'(pad_b), 64'(eb));
      chk("model valid", {62'd0, valid_b, valid_a}, {62'd0, ev, ev});
      chk("model phase", {62'd0, phase_b, phase_a}, {62'd0, ph, ph});
    end
  end

  task automatic do_tick();
    @(negedge clk_sys);
    vsync_tick = 1'b1;
    @(negedge clk_sys);
    vsync_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset_n = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  task automatic pulse12();
    @(negedge clk_sys);
    joy_in[12] = 1'b1;
    repeat (3) @(negedge clk_sys);
    joy_in[12] = 1'b0;
  endtask

  initial begin
    bit seq[8];
    seq = '{1, 0, 0, 1, 1, 0, 0, 1};
    repeat (2) @(negedge clk_sys);
    chk("reset pad", 64'(pad_a), 64'h0);
    chk("reset phase", {63'd0, phase_a}, 64'd1);
    reset_n = 1'b1;

    joy_in = {32'h0000_0FF0, 32'h0};
    do_tick();
    chk("map pad", 64'(pad_a), 64'h00FF_0000);
    chk("map valid", {63'd0, valid_a}, 64'd1);
    @(negedge clk_sys);
    chk("map valid drop", {63'd0, valid_a}, 64'd0);

    joy_in = {32'h0, 32'h0000_000F};
    do_tick();
    chk("socd on", 64'(pad_a[15:0]), 64'h0000);
    chk("socd off", 64'(pad_b[15:0]), 64'h0F00);

    do_reset();
    joy_in = {32'h0, 32'h0000_0010};
    turbo_en = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      do_tick();
      chk($sformatf("turbo tick%0d", i + 1), {63'd0, pad_a[0]},
          {63'd0, seq[i]});
    end
    turbo_en = '0;

    do_reset();
    joy_in = '0;
    pulse12();
    pulse12();
    do_tick();
    chk("mode twice", {63'd0, pad_a[12]}, 64'd0);
    pulse12();
    do_tick();
    chk("mode once", {63'd0, pad_a[12]}, 64'd1);
    joy_in[12] = 1'b1;
    do_reset();
    do_tick();
    chk("mode held reset", {63'd0, pad_a[12]}, 64'd0);

    joy_in = {32'h0000_0FF0, 32'h0000_0FF0};
    do_tick();
    @(negedge clk_sys);
    vsync_tick = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("async pad", 64'(pad_a), 64'h0);
    chk("async phase", {62'd0, valid_a, phase_a}, 64'd1);
    @(negedge clk_sys);
    chk("rst tick pad", 64'(pad_a), 64'h0);
    vsync_tick = 1'b0;
    reset_n = 1'b1;
    @(negedge clk_sys);
    chk("post rst valid", {62'd0, valid_a, phase_a}, 64'd1);

    joy_in = '0;
    @(negedge clk_sys);
    joy_in[13] = 1'b1;
    vsync_tick = 1'b1;
    @(negedge clk_sys);
    vsync_tick = 1'b0;
    chk("coincident mode2", {63'd0, pad_a[13]}, 64'd1);

    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_sys);
      joy_in = {$urandom(), $urandom()};
      turbo_en = 4'($urandom());
      vsync_tick = ($urandom_range(0, 2) == 0);
      reset_n = ($urandom_range(0, 99) != 0);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    vsync_tick = 1'b0;
    repeat (2) @(negedge clk_sys);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/joy_turbo_map.md
JOY_TURBO_MAP -- requirements
Module: joy_turbo_map

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, meaning number of controller ports (legal 1..8).
REQ-002 SHALL have parameter TURBO_FRAMES, default 4, meaning frame ticks per turbo half-period (legal 1..255).
REQ-003 SHALL have parameter SOCD_NEUTRAL, default 1, meaning opposing directions cancel when 1.
REQ-004 SHALL have port clk_sys  input  1  system clock; the only clock; all state on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port joy_in  input  32*N_PORTS  per-port joystick word, port p at [32p+31:32p], active-high.
REQ-007 SHALL have port turbo_en  input  2*N_PORTS  per-port turbo enable: bit 2p for button I, bit 2p+1 for button II.
REQ-008 SHALL have port vsync_tick  input  1  one-cycle frame strobe.
REQ-009 SHALL have port pad_out  output  16*N_PORTS  registered PC-FX pad word per port.
REQ-010 SHALL have port pad_valid  output  1  one-cycle pulse marking a pad_out update.
REQ-011 SHALL have port turbo_phase  output  1  current turbo phase, 1 = turbo buttons pass.

Function
REQ-012 SHALL map input bits: [0] right, [1] left, [2] down, [3] up, [4] I, [5] II, [6] select, [7] run, [8] III, [9] IV, [10] V, [11] VI, [12] mode1 toggle, [13] mode2 toggle; [31:14] ignored.
REQ-013 SHALL format pad word: [0] I, [1] II, [2] III, [3] IV, [4] V, [5] VI, [6] select, [7] run, [8] up, [9] right, [10] down, [11] left, [12] mode1, [13] mode2, [15:14] = 0.
REQ-014 SHALL, when SOCD_NEUTRAL=1, clear both up and down if both pressed, and both left and right if both pressed; when 0, pass raw.
REQ-015 SHALL keep one shared 8-bit frame counter, incremented on each vsync_tick; at value TURBO_FRAMES-1 with tick it wraps to 0 and turbo_phase toggles.
REQ-016 SHALL gate button I (II) of port p with turbo_phase when turbo_en bit is 1; otherwise pass raw.
REQ-017 SHALL keep per-port mode1/mode2 registers, each toggled on a rising edge of its input bit (bit sampled every clk_sys against a one-cycle-delayed copy); level held is no toggle.
REQ-018 SHALL update pad_out only on the cycle after vsync_tick=1, from joy_in sampled that tick cycle and the post-tick turbo_phase and mode values.
REQ-019 SHALL pulse pad_valid high for exactly the cycle pad_out updates (one cycle after vsync_tick).
REQ-020 SHALL, on back-to-back vsync_tick, update pad_out and pulse pad_valid each cycle.
REQ-021 SHALL, when a mode edge and vsync_tick coincide, reflect the toggled mode in that update.
REQ-022 SHALL ignore turbo_en changes between ticks; only the value at the tick cycle matters.
REQ-023 SHALL have latency: joy_in change to pad_out = wait for next vsync_tick, then 1 cycle.

Reset
REQ-024 SHALL, while reset_n=0, force pad_out=0, pad_valid=0, turbo_phase=1, frame counter=0, mode registers=0, edge-detect history=0.
REQ-025 SHALL, on reset_n deassertion, treat an input bit 12/13 already high as no edge.
REQ-026 SHALL abandon any in-progress update when reset asserts mid-cycle; no pad_valid in the first cycle after release unless vsync_tick was high in it.

Verification
REQ-027 SHALL verify mapping: N_PORTS=2, joy_in port1=0x0000_0FF0, tick -> next cycle pad_out[31:16]=0x00FF, port0 0x0000, pad_valid=1 one cycle.
REQ-028 SHALL verify SOCD: port0 joy=0x0000_000F, SOCD_NEUTRAL=1, tick -> pad_out[15:0]=0x0000; SOCD_NEUTRAL=0 -> 0x0F00.
REQ-029 SHALL verify turbo: TURBO_FRAMES=2, turbo_en[0]=1, I held, 8 ticks -> button I sequence 1,0,0,1,1,0,0,1 (phase toggles on ticks 2,4,6,8; initial phase 1).
REQ-030 SHALL verify mode toggle: pulse bit12 high 3 cycles twice, then tick -> pad_out bit12=0; once -> 1; held high across reset release -> 0.
REQ-031 SHALL verify reset mid-frame: reset_n low during tick cycle -> pad_out=0, pad_valid=0, turbo_phase=1 next cycle.
REQ-032 SHALL verify coincident events: bit13 rising on tick cycle -> pad_out bit13=1 in that update.
